// File: rtl/sr_cmd_conditioner_pkg.sv
// Shared constants for the SR command conditioner: FSM encoding and parameter defaults.
package sr_cmd_conditioner_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EMIT_S  = 2'd1;
    localparam logic [1:0] ST_EMIT_R  = 2'd2;
    localparam logic [1:0] ST_HOLDOFF = 2'd3;

    localparam int DB_CYCLES_DEF = 16;
    localparam int CNT_W_DEF     = 5;
    localparam int HOLDOFF_DEF   = 8;

endpackage

// File: rtl/sr_cmd_conditioner_debounce.sv
// One button channel: 2-flop synchroniser, debounce counter, stable level and
// a one-cycle event on each debounced rising edge.
module sr_debounce_ch #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic stable_o,
    output logic ev_o
);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             stable_dly_q;

    // Any sample equal to the stable level restarts the qualification window.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_W'(DB_CYCLES - 1))
                stable_d = sync_q[1];
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], btn_i};
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
        end
    end

    assign stable_o = stable_q;
    assign ev_o     = stable_q & ~stable_dly_q;

endmodule

// File: rtl/sr_cmd_conditioner.sv
// Conditions two raw push-buttons into mutually exclusive single-cycle s/r
// command pulses with a post-pulse lockout and sticky conflict/overrun flags.
module sr_cmd_conditioner
    import sr_cmd_conditioner_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int HOLDOFF   = HOLDOFF_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_s,
    input  logic btn_r,
    input  logic clr_flags,
    output logic s,
    output logic r,
    output logic s_stable,
    output logic r_stable,
    output logic conflict,
    output logic overrun
);

    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    logic          ev_s, ev_r;
    logic [1:0]    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          conflict_q, conflict_d;
    logic          overrun_q, overrun_d;
    logic          s_q, r_q;

    sr_debounce_ch #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_s (
        .clk_i(clk), .rst_i(rst), .btn_i(btn_s), .stable_o(s_stable), .ev_o(ev_s)
    );

    sr_debounce_ch #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_r (
        .clk_i(clk), .rst_i(rst), .btn_i(btn_r), .stable_o(r_stable), .ev_o(ev_r)
    );

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        conflict_d = conflict_q;
        overrun_d  = overrun_q;
        if (clr_flags) begin
            conflict_d = 1'b0;
            overrun_d  = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (ev_s && ev_r)
                    conflict_d = 1'b1;
                else if (ev_s)
                    state_d = ST_EMIT_S;
                else if (ev_r)
                    state_d = ST_EMIT_R;
            end
            ST_EMIT_S, ST_EMIT_R: begin
                state_d = ST_HOLDOFF;
                hold_d  = HW'(HOLDOFF - 1);
            end
            ST_HOLDOFF: begin
                if (hold_q == '0)
                    state_d = ST_IDLE;
                else
                    hold_d = hold_q - 1'b1;
            end
        endcase
        // Events outside IDLE are dropped; the flag set overrides a same-cycle clear.
        if (state_q != ST_IDLE && (ev_s || ev_r))
            overrun_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            conflict_q <= 1'b0;
            overrun_q  <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            conflict_q <= conflict_d;
            overrun_q  <= overrun_d;
            s_q        <= (state_d == ST_EMIT_S);
            r_q        <= (state_d == ST_EMIT_R);
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign conflict = conflict_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Directed + randomised bench: expected pulses go into a scoreboard queue and
// are matched against observed s/r pulses by a negedge monitor.
module tb_sr_cmd_conditioner;

    localparam int DB = 4;
    localparam int HO = 3;

    logic clk = 1'b0, rst = 1'b1, btn_s = 1'b0, btn_r = 1'b0, clr_flags = 1'b0;
    logic s, r, s_stable, r_stable, conflict, overrun;

    typedef struct {
        bit is_r;
        int at;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   ntot = 0;
    int   npass = 0;
    int   last_pulse = -100;
    int   rand_pulses = 0;
    bit   rand_mode = 1'b0;

    sr_cmd_conditioner #(.DB_CYCLES(DB), .CNT_W(5), .HOLDOFF(HO)) dut (
        .clk(clk), .rst(rst), .btn_s(btn_s), .btn_r(btn_r), .clr_flags(clr_flags),
        .s(s), .r(r), .s_stable(s_stable), .r_stable(r_stable),
        .conflict(conflict), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: exclusivity every cycle, lockout spacing and scoreboard match per pulse.
    always @(negedge clk) begin
        if (!rst) begin
            chk("s_r_exclusive", {31'b0, s & r}, 32'd0);
            if (s | r) begin
                if (last_pulse >= 0) chk("pulse_gap_ge4", {31'b0, (cyc - last_pulse) >= 4}, 32'd1);
                last_pulse = cyc;
                if (rand_mode) begin
                    rand_pulses++;
                end else begin
                    chk("sb_has_expected", {31'b0, sbq.size() > 0}, 32'd1);
                    if (sbq.size() > 0) begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk("pulse_is_r", {31'b0, r}, {31'b0, e.is_r});
                        chk("pulse_cycle", cyc, e.at);
                    end
                end
            end
        end
    end

    initial begin
        int base;
        bit pat [5];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset state, both before and across clock edges
        #2 chk("reset_outs_t2", {26'b0, s, r, s_stable, r_stable, conflict, overrun}, 32'd0);
        negs(2);
        chk("reset_outs_clk", {26'b0, s, r, s_stable, r_stable, conflict, overrun}, 32'd0);
        rst = 1'b0;
        negs(2);

        // 1. Clean press
        btn_s = 1'b1; base = cyc;
        sbq.push_back('{1'b0, base + 7});
        negs(5); chk("s1_stable_e5", {31'b0, s_stable}, 32'd0);
        negs(1); chk("s1_stable_e6", {31'b0, s_stable}, 32'd1);
        negs(14);
        chk("s1_flags", {30'b0, conflict, overrun}, 32'd0);
        chk("s1_r_stable", {31'b0, r_stable}, 32'd0);
        btn_s = 1'b0;
        negs(10);
        chk("s1_release_stable", {31'b0, s_stable}, 32'd0);
        chk("s1_sb_empty", sbq.size(), 32'd0);

        // 2. Bounce 1,0,1,1,0 then held
        base = cyc;
        sbq.push_back('{1'b0, base + 12});
        for (int i = 0; i < 5; i++) begin
            btn_s = pat[i];
            negs(1);
        end
        btn_s = 1'b1;
        negs(5); chk("s2_stable_e10", {31'b0, s_stable}, 32'd0);
        negs(1); chk("s2_stable_e11", {31'b0, s_stable}, 32'd1);
        negs(5);
        btn_s = 1'b0;
        negs(10);
        chk("s2_release_stable", {31'b0, s_stable}, 32'd0);
        chk("s2_sb_empty", sbq.size(), 32'd0);

        // 3. Simultaneous press -> conflict, cleared by clr_flags
        btn_s = 1'b1; btn_r = 1'b1; base = cyc;
        negs(6); chk("s3_conflict_e6", {31'b0, conflict}, 32'd0);
        negs(1); chk("s3_conflict_e7", {31'b0, conflict}, 32'd1);
        chk("s3_both_stable", {30'b0, s_stable, r_stable}, 32'd3);
        negs(2); clr_flags = 1'b1;
        negs(1); clr_flags = 1'b0;
        chk("s3_conflict_clr", {31'b0, conflict}, 32'd0);
        btn_s = 1'b0; btn_r = 1'b0;
        negs(10);
        chk("s3_sb_empty", sbq.size(), 32'd0);

        // 4. Reset event inside the holdoff window is dropped
        btn_s = 1'b1; base = cyc;
        sbq.push_back('{1'b0, base + 7});
        negs(3); btn_r = 1'b1;
        negs(6); chk("s4_overrun_e9", {31'b0, overrun}, 32'd0);
        negs(1); chk("s4_overrun_e10", {31'b0, overrun}, 32'd1);
        chk("s4_r_stable", {31'b0, r_stable}, 32'd1);
        btn_s = 1'b0; btn_r = 1'b0;
        negs(10);
        chk("s4_overrun_sticky", {30'b0, conflict, overrun}, 32'd1);
        chk("s4_sb_empty", sbq.size(), 32'd0);

        // 5. Async reset during EMIT_S, button still held at release
        btn_s = 1'b1; base = cyc;
        sbq.push_back('{1'b0, base + 7});
        negs(7);
        chk("s5_s_before_rst", {31'b0, s}, 32'd1);
        #2 rst = 1'b1;
        #1 chk("s5_async_clear", {28'b0, s, s_stable, conflict, overrun}, 32'd0);
        #1 rst = 1'b0;
        base = cyc;
        sbq.push_back('{1'b0, base + 7});
        negs(17);
        btn_s = 1'b0;
        negs(10);
        chk("s5_sb_empty", sbq.size(), 32'd0);

        // 6. Random bouncing on both buttons
        rand_mode = 1'b1;
        repeat (10000) begin
            @(negedge clk);
            if ($urandom_range(5) == 0) btn_s = ~btn_s;
            if ($urandom_range(5) == 0) btn_r = ~btn_r;
        end
        btn_s = 1'b0; btn_r = 1'b0;
        negs(20);
        rand_mode = 1'b0;
        chk("s6_some_pulses", {31'b0, rand_pulses > 0}, 32'd1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
